// File: rtl/rob_commit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rob_commit_ctrl_pkg
//  Description : Shared CPU constants and the reorder-buffer commit FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rob_commit_ctrl_pkg;

    // log2 of the reorder-buffer depth
    localparam int unsigned c_ROB_WIDTH = 3;

    // Register tag meaning "no architectural destination"
    localparam logic [5:0] c_NON_DEP = 6'b100000;

    // Commit controller states
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH_PEND = 2'd1,
        ST_FLUSH      = 2'd2
    } rob_state_e;

endpackage : rob_commit_ctrl_pkg
`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rob_commit_ctrl
//  Description : Reorder-buffer circular queue with in-order allocation,
//                out-of-order completion over the CDB, single-entry in-order
//                commit to the register file, and a two-step flush on a
//                committed mispredict.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = c_ROB_WIDTH,
    parameter logic [5:0]  NON_DEP   = c_NON_DEP
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    // allocation
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_rd,
    output logic                 alloc_ready,
    output logic [ROB_WIDTH-1:0] alloc_index,
    // completion
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_index,
    input  logic [31:0]          cdb_data,
    input  logic                 cdb_mispredict,
    // dispatch query
    input  logic [ROB_WIDTH-1:0] query_index,
    output logic                 query_ready,
    output logic [31:0]          query_data,
    // register-file drive
    output logic                 RoB_update_en,
    output logic [5:0]           RoB_update_reg,
    output logic [ROB_WIDTH-1:0] RoB_update_index,
    output logic [31:0]          RoB_update_data,
    output logic                 flush_signal
);

    localparam int             c_DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] c_FULL = (ROB_WIDTH+1)'(c_DEPTH);

    // Entry storage, one flat register per field
    logic                 r_busy    [c_DEPTH];
    logic                 r_ready   [c_DEPTH];
    logic                 r_mispred [c_DEPTH];
    logic [4:0]           r_rd      [c_DEPTH];
    logic [31:0]          r_data    [c_DEPTH];

    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;
    rob_state_e           r_state;

    logic                 w_run;
    logic                 w_alloc;
    logic                 w_commit;
    logic                 w_cdb_hit;
    logic [5:0]           w_commit_reg;

    // Only registered state feeds alloc_ready, so a full queue cannot
    // accept an allocation in the same cycle its head commits.
    assign w_run        = rdy_in && (r_state == ST_RUN);
    assign alloc_ready  = w_run && (r_count < c_FULL);
    assign alloc_index  = r_tail;
    assign w_alloc      = alloc_valid && alloc_ready;
    assign w_commit     = w_run && r_busy[r_head] && r_ready[r_head];
    assign w_cdb_hit    = w_run && cdb_valid && r_busy[cdb_index];
    assign w_commit_reg = (r_rd[r_head] != 5'd0) ? {1'b0, r_rd[r_head]} : NON_DEP;

    // Query read with same-cycle bypass of a matching CDB broadcast
    always_comb begin
        query_ready = r_ready[query_index];
        query_data  = r_data[query_index];
        if (cdb_valid && (cdb_index == query_index)) begin
            query_ready = 1'b1;
            query_data  = cdb_data;
        end
    end

    // Queue state, commit outputs and flush FSM
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_busy[i]    <= 1'b0;
                r_ready[i]   <= 1'b0;
                r_mispred[i] <= 1'b0;
                r_rd[i]      <= 5'd0;
                r_data[i]    <= 32'd0;
            end
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_state          <= ST_RUN;
            RoB_update_en    <= 1'b0;
            RoB_update_reg   <= NON_DEP;
            RoB_update_index <= '0;
            RoB_update_data  <= 32'd0;
            flush_signal     <= 1'b0;
        end else if (rdy_in) begin
            RoB_update_en <= w_commit;
            if (w_commit) begin
                RoB_update_index <= r_head;
                RoB_update_data  <= r_data[r_head];
                RoB_update_reg   <= w_commit_reg;
            end
            flush_signal <= (r_state == ST_FLUSH_PEND);

            case (r_state)
                ST_RUN: begin
                    if (w_cdb_hit) begin
                        r_ready[cdb_index]   <= 1'b1;
                        r_data[cdb_index]    <= cdb_data;
                        r_mispred[cdb_index] <= cdb_mispredict;
                    end
                    if (w_alloc) begin
                        r_busy[r_tail]    <= 1'b1;
                        r_ready[r_tail]   <= 1'b0;
                        r_mispred[r_tail] <= 1'b0;
                        r_rd[r_tail]      <= alloc_rd;
                        r_tail            <= r_tail + ROB_WIDTH'(1);
                    end
                    if (w_commit) begin
                        r_busy[r_head] <= 1'b0;
                        r_head         <= r_head + ROB_WIDTH'(1);
                        if (r_mispred[r_head]) begin
                            r_state <= ST_FLUSH_PEND;
                        end
                    end
                    if (w_alloc && !w_commit) begin
                        r_count <= r_count + (ROB_WIDTH+1)'(1);
                    end else if (!w_alloc && w_commit) begin
                        r_count <= r_count - (ROB_WIDTH+1)'(1);
                    end
                end
                ST_FLUSH_PEND: begin
                    r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    for (int i = 0; i < c_DEPTH; i++) begin
                        r_busy[i] <= 1'b0;
                    end
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule : rob_commit_ctrl
`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_commit_ctrl
//  Description : Self-checking bench for rob_commit_ctrl: vector table,
//                directed corner sequences and a randomized run against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit_ctrl;

    localparam int         W  = 3;
    localparam int         N  = 8;
    localparam logic [5:0] ND = 6'b100000;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          alloc_valid = 1'b0;
    logic [4:0]    alloc_rd = '0;
    logic          alloc_ready;
    logic [W-1:0]  alloc_index;
    logic          cdb_valid = 1'b0;
    logic [W-1:0]  cdb_index = '0;
    logic [31:0]   cdb_data = '0;
    logic          cdb_mispredict = 1'b0;
    logic [W-1:0]  query_index = '0;
    logic          query_ready;
    logic [31:0]   query_data;
    logic          RoB_update_en;
    logic [5:0]    RoB_update_reg;
    logic [W-1:0]  RoB_update_index;
    logic [31:0]   RoB_update_data;
    logic          flush_signal;

    rob_commit_ctrl #(.ROB_WIDTH(W), .NON_DEP(ND)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_index(alloc_index),
        .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict),
        .query_index(query_index), .query_ready(query_ready), .query_data(query_data),
        .RoB_update_en(RoB_update_en), .RoB_update_reg(RoB_update_reg),
        .RoB_update_index(RoB_update_index), .RoB_update_data(RoB_update_data),
        .flush_signal(flush_signal)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        alloc_valid    = 1'b0;
        alloc_rd       = '0;
        cdb_valid      = 1'b0;
        cdb_index      = '0;
        cdb_data       = '0;
        cdb_mispredict = 1'b0;
    endtask

    // ---------------- reference model (queue of live instructions) ----------
    typedef struct {
        int         idx;
        logic [4:0] rd;
        bit         done;
        logic [31:0] data;
        bit         mis;
    } ment_t;

    ment_t       mq[$];
    int          m_tail;
    int          m_fw;      // cycles left in the flush sequence: 2 pending, 1 flushing
    logic        m_en, m_flush;
    logic [5:0]  m_reg;
    logic [2:0]  m_idx;
    logic [31:0] m_data;

    function automatic int find(input int idx);
        for (int k = 0; k < mq.size(); k++) if (mq[k].idx == idx) return k;
        return -1;
    endfunction

    task automatic do_reset();
        rst_in = 1'b1;
        idle();
        tick();
        tick();
        rst_in = 1'b0;
        mq.delete();
        m_tail = 0; m_fw = 0;
        m_en = 0; m_flush = 0; m_reg = ND; m_idx = 0; m_data = 0;
    endtask

    // Advance the model across one edge with the currently driven inputs
    task automatic model_step(input bit acc);
        bit          commit, cmis;
        logic [4:0]  crd;
        int          p;
        if (!rdy_in) return;
        commit = (m_fw == 0) && (mq.size() > 0) && mq[0].done;
        if (commit) begin
            crd    = mq[0].rd;
            m_idx  = 3'(mq[0].idx);
            m_data = mq[0].data;
            m_reg  = (crd == 0) ? ND : {1'b0, crd};
            cmis   = mq[0].mis;
        end else begin
            cmis = 0;
        end
        m_en    = commit;
        m_flush = (m_fw == 2);
        if (m_fw == 2) m_fw = 1;
        else if (m_fw == 1) begin
            m_fw = 0; mq.delete(); m_tail = 0;
        end else begin
            if (cdb_valid) begin
                p = find(int'(cdb_index));
                if (p >= 0) begin
                    mq[p].done = 1; mq[p].data = cdb_data; mq[p].mis = cdb_mispredict;
                end
            end
            if (commit) begin
                void'(mq.pop_front());
                if (cmis) m_fw = 2;
            end
            if (acc && alloc_valid) begin
                mq.push_back('{idx: m_tail, rd: alloc_rd, done: 0, data: 0, mis: 0});
                m_tail = (m_tail + 1) % N;
            end
        end
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct {
        logic        av;  logic [4:0]  ard;
        logic        cv;  logic [2:0]  ci;  logic [31:0] cd;
        logic        ar;  logic [2:0]  ai;
        logic        en;  logic [5:0]  rg;  logic [2:0]  ix; logic [31:0] dt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   p;
        bit   exp_ar, fwd;

        // alloc rd=1,2,0 then complete 2,0,1 with A,B,C; commits follow in order
        tbl[0] = '{1, 5'd1, 0, 3'd0, 32'h0, 1, 3'd0, 0, 6'd0, 3'd0, 32'h0};
        tbl[1] = '{1, 5'd2, 0, 3'd0, 32'h0, 1, 3'd1, 0, 6'd0, 3'd0, 32'h0};
        tbl[2] = '{1, 5'd0, 0, 3'd0, 32'h0, 1, 3'd2, 0, 6'd0, 3'd0, 32'h0};
        tbl[3] = '{0, 5'd0, 1, 3'd2, 32'hA, 1, 3'd3, 0, 6'd0, 3'd0, 32'h0};
        tbl[4] = '{0, 5'd0, 1, 3'd0, 32'hB, 1, 3'd3, 0, 6'd0, 3'd0, 32'h0};
        tbl[5] = '{0, 5'd0, 1, 3'd1, 32'hC, 1, 3'd3, 1, 6'd1, 3'd0, 32'hB};
        tbl[6] = '{0, 5'd0, 0, 3'd0, 32'h0, 1, 3'd3, 1, 6'd2, 3'd1, 32'hC};
        tbl[7] = '{0, 5'd0, 0, 3'd0, 32'h0, 1, 3'd3, 1, ND,   3'd2, 32'hA};
        tbl[8] = '{0, 5'd0, 0, 3'd0, 32'h0, 1, 3'd3, 0, 6'd0, 3'd0, 32'h0};

        do_reset();
        chk("reset_en",    RoB_update_en, 0);
        chk("reset_reg",   RoB_update_reg, ND);
        chk("reset_idx",   RoB_update_index, 0);
        chk("reset_data",  RoB_update_data, 0);
        chk("reset_flush", flush_signal, 0);
        chk("reset_aready", alloc_ready, 1);
        chk("reset_aidx",  alloc_index, 0);

        for (int i = 0; i < 9; i++) begin
            alloc_valid = tbl[i].av; alloc_rd = tbl[i].ard;
            cdb_valid = tbl[i].cv; cdb_index = tbl[i].ci; cdb_data = tbl[i].cd;
            cdb_mispredict = 1'b0;
            #1;
            chk("tbl_aready", alloc_ready, tbl[i].ar);
            chk("tbl_aidx", alloc_index, tbl[i].ai);
            tick();
            chk("tbl_en", RoB_update_en, tbl[i].en);
            if (tbl[i].en) begin
                chk("tbl_reg", RoB_update_reg, tbl[i].rg);
                chk("tbl_idx", RoB_update_index, tbl[i].ix);
                chk("tbl_data", RoB_update_data, tbl[i].dt);
            end
        end
        idle();

        // full queue: alloc_ready returns only after the commit edge, tail wraps
        do_reset();
        for (int i = 0; i < N; i++) begin
            alloc_valid = 1; alloc_rd = 5'(i + 1); tick();
        end
        idle();
        chk("full_aready", alloc_ready, 0);
        cdb_valid = 1; cdb_index = 0; cdb_data = 32'h55; tick();
        idle();
        chk("full_aready_precommit", alloc_ready, 0);
        tick();
        chk("full_commit_en", RoB_update_en, 1);
        chk("full_commit_data", RoB_update_data, 32'h55);
        chk("full_aready_after", alloc_ready, 1);
        chk("full_aidx_wrap", alloc_index, 0);

        // mispredict on entry 1 of 4
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_rd = 5'(i + 1); tick();
        end
        idle();
        cdb_valid = 1; cdb_index = 0; cdb_data = 32'h10; tick();
        cdb_index = 1; cdb_data = 32'h11; cdb_mispredict = 1; tick();
        chk("mis_commit0_idx", RoB_update_index, 0);
        idle();
        tick();
        chk("mis_commit1_en", RoB_update_en, 1);
        chk("mis_commit1_idx", RoB_update_index, 1);
        chk("mis_commit1_flush", flush_signal, 0);
        chk("mis_pend_aready", alloc_ready, 0);
        tick();
        chk("mis_flush_high", flush_signal, 1);
        chk("mis_flush_en", RoB_update_en, 0);
        tick();
        chk("mis_flush_low", flush_signal, 0);
        chk("mis_after_aready", alloc_ready, 1);
        chk("mis_after_aidx", alloc_index, 0);

        // same-cycle query bypass
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1; alloc_rd = 5'd3; tick();
        end
        idle();
        query_index = 3'd5;
        #1;
        chk("byp_pre_ready", query_ready, 0);
        cdb_valid = 1; cdb_index = 3'd5; cdb_data = 32'h1234_5678;
        #1;
        chk("byp_ready", query_ready, 1);
        chk("byp_data", query_data, 32'h1234_5678);
        idle();

        // rdy_in low holds everything
        do_reset();
        for (int i = 0; i < 2; i++) begin
            alloc_valid = 1; alloc_rd = 5'd7; tick();
        end
        idle();
        cdb_valid = 1; cdb_index = 0; cdb_data = 32'h77; tick();
        idle();
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_en", RoB_update_en, 0);
            chk("pause_aready", alloc_ready, 0);
            chk("pause_aidx", alloc_index, 2);
        end
        rdy_in = 1;
        tick();
        chk("resume_en", RoB_update_en, 1);
        chk("resume_idx", RoB_update_index, 0);
        chk("resume_data", RoB_update_data, 32'h77);

        // reset during FLUSH_PEND
        do_reset();
        for (int i = 0; i < 2; i++) begin
            alloc_valid = 1; alloc_rd = 5'd4; tick();
        end
        idle();
        cdb_valid = 1; cdb_index = 0; cdb_data = 32'h99; cdb_mispredict = 1; tick();
        idle();
        tick();
        chk("rstp_commit_en", RoB_update_en, 1);
        chk("rstp_pend_aready", alloc_ready, 0);
        rst_in = 1;
        tick();
        chk("rstp_flush", flush_signal, 0);
        chk("rstp_aready", alloc_ready, 1);
        chk("rstp_aidx", alloc_index, 0);
        chk("rstp_reg", RoB_update_reg, ND);
        rst_in = 0;
        tick();
        chk("rstp_flush_next", flush_signal, 0);
        chk("rstp_aready_next", alloc_ready, 1);

        // randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy_in         = ($urandom % 10) != 0;
            alloc_valid    = ($urandom % 5) < 3;
            alloc_rd       = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            cdb_valid      = $urandom % 2;
            if (mq.size() > 0 && ($urandom % 4) != 0)
                cdb_index = 3'(mq[$urandom_range(mq.size() - 1)].idx);
            else
                cdb_index = 3'($urandom);
            cdb_data       = $urandom;
            cdb_mispredict = ($urandom % 12) == 0;
            query_index    = (($urandom % 3) == 0) ? cdb_index : 3'($urandom);
            #1;
            exp_ar = rdy_in && (m_fw == 0) && (mq.size() < N);
            chk("rnd_aready", alloc_ready, exp_ar);
            chk("rnd_aidx", alloc_index, m_tail);
            fwd = cdb_valid && (cdb_index == query_index);
            p   = find(int'(query_index));
            if (fwd) begin
                chk("rnd_q_fwd_ready", query_ready, 1);
                chk("rnd_q_fwd_data", query_data, cdb_data);
            end else if (p >= 0) begin
                chk("rnd_q_ready", query_ready, mq[p].done);
                if (mq[p].done) chk("rnd_q_data", query_data, mq[p].data);
            end
            model_step(exp_ar);
            tick();
            chk("rnd_en", RoB_update_en, m_en);
            chk("rnd_flush", flush_signal, m_flush);
            chk("rnd_reg", RoB_update_reg, m_reg);
            chk("rnd_idx", RoB_update_index, m_idx);
            chk("rnd_data", RoB_update_data, m_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rob_commit_ctrl
`default_nettype wire
